// File: rtl/imager_pkg.sv
// Shared types and default widths for the imager window packer.
// The window config struct is held at the package default widths.
package imager_pkg;

    localparam int DEF_DATA_WIDTH     = 10;
    localparam int DEF_NUM_ROWS_WIDTH = 12;
    localparam int DEF_NUM_COLS_WIDTH = 12;

    typedef struct packed {
        logic [DEF_NUM_ROWS_WIDTH-1:0] row_start;
        logic [DEF_NUM_COLS_WIDTH-1:0] col_start;
        logic [DEF_NUM_ROWS_WIDTH-1:0] rows;
        logic [DEF_NUM_COLS_WIDTH-1:0] cols;
    } win_cfg_t;

endpackage

// File: rtl/imager_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with flush.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module imager_sync_fifo #(
    parameter int WIDTH      = 12,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  do_push, do_pop;
    logic [WIDTH-1:0]      mem_q [DEPTH];

    assign full    = (count_q == (DEPTH_LOG2+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign rd_data = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop & ~empty & ~flush;
        do_push  = push & ~flush & (~full | do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      count_d = count_q + 1'b1;
            else if (!do_push && do_pop) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; the head is only observed while non-empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/imager_window_packer.sv
// Crops a window from the imager fv/lv/dat bus into a FWFT valid/ready stream.
// Optional per-frame statistics are built when IMAGER_WINDOW_STATS_EN is defined.
module imager_window_packer
    import imager_pkg::*;
#(
    parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int NUM_ROWS_WIDTH  = DEF_NUM_ROWS_WIDTH,
    parameter int NUM_COLS_WIDTH  = DEF_NUM_COLS_WIDTH,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic [NUM_ROWS_WIDTH-1:0] win_row_start,
    input  logic [NUM_COLS_WIDTH-1:0] win_col_start,
    input  logic [NUM_ROWS_WIDTH-1:0] win_rows,
    input  logic [NUM_COLS_WIDTH-1:0] win_cols,
    input  logic                      fv,
    input  logic                      lv,
    input  logic [DATA_WIDTH-1:0]     dat,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH-1:0]     out_dat,
    output logic                      out_sof,
    output logic                      out_eol,
    output logic                      overflow,
    output logic                      frame_done,
    output logic [31:0]               stats_sum,
    output logic [DATA_WIDTH-1:0]     stats_min,
    output logic [DATA_WIDTH-1:0]     stats_max,
    output logic                      stats_valid
);

    localparam int RW = NUM_ROWS_WIDTH + 1;
    localparam int CW = NUM_COLS_WIDTH + 1;
    localparam int EW = DATA_WIDTH + 2;

    logic                  fv_q, lv_q, fv_prev_q, lv_prev_q;
    logic [DATA_WIDTH-1:0] dat_q;
    logic                  fv_rise, fv_fall, lv_fall;
    logic                  armed_q, armed_d;
    logic [CW-1:0]         col_q, col_d;
    logic [RW-1:0]         row_q, row_d, row_cur;
    win_cfg_t              cfg_q, cfg_d, cfg_in, cfg_cur;
    logic [RW-1:0]         rs_ext, re_ext;
    logic [CW-1:0]         cs_ext, ce_ext;
    logic                  in_win, px_sof, px_eol;
    logic                  ovf_q, ovf_d;
    logic                  frame_done_q, frame_done_d;
    logic                  fifo_full, fifo_empty, fifo_pop;
    logic [EW-1:0]         fifo_wdata, fifo_rdata;

    assign fv_rise = fv_q & ~fv_prev_q;
    assign fv_fall = ~fv_q & fv_prev_q;
    assign lv_fall = ~lv_q & lv_prev_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fv_q      <= 1'b0;
            lv_q      <= 1'b0;
            dat_q     <= '0;
            fv_prev_q <= 1'b0;
            lv_prev_q <= 1'b0;
        end else begin
            fv_q      <= fv;
            lv_q      <= lv;
            dat_q     <= dat;
            fv_prev_q <= fv_q;
            lv_prev_q <= lv_q;
        end
    end

    // On the fv-rise cycle the new config and row 0 apply to the pixel already present.
    always_comb begin
        cfg_in.row_start = DEF_NUM_ROWS_WIDTH'(win_row_start);
        cfg_in.col_start = DEF_NUM_COLS_WIDTH'(win_col_start);
        cfg_in.rows      = DEF_NUM_ROWS_WIDTH'(win_rows);
        cfg_in.cols      = DEF_NUM_COLS_WIDTH'(win_cols);
        cfg_cur = fv_rise ? cfg_in : cfg_q;
        row_cur = fv_rise ? '0 : row_q;
        rs_ext  = RW'(cfg_cur.row_start);
        re_ext  = rs_ext + RW'(cfg_cur.rows);
        cs_ext  = CW'(cfg_cur.col_start);
        ce_ext  = cs_ext + CW'(cfg_cur.cols);
        in_win  = enable & fv_q & lv_q & (armed_q | fv_rise)
                & (row_cur >= rs_ext) & (row_cur < re_ext)
                & (col_q >= cs_ext) & (col_q < ce_ext);
        px_sof  = (row_cur == rs_ext) && (col_q == cs_ext);
        px_eol  = (col_q == ce_ext - 1'b1);
    end

    assign fifo_pop   = ~fifo_empty & out_ready;
    assign fifo_wdata = {dat_q, px_sof, px_eol};

    always_comb begin
        cfg_d        = fv_rise ? cfg_in : cfg_q;
        armed_d      = armed_q | fv_rise;
        col_d        = col_q;
        row_d        = row_q;
        ovf_d        = ovf_q | (in_win & fifo_full & ~fifo_pop);
        frame_done_d = enable & fv_fall;
        if (lv_fall)   col_d = '0;
        else if (lv_q) col_d = col_q + 1'b1;
        if (fv_rise)      row_d = '0;
        else if (lv_fall) row_d = row_q + 1'b1;
        if (!enable) begin
            armed_d = 1'b0;
            col_d   = '0;
            row_d   = '0;
            ovf_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cfg_q        <= '0;
            armed_q      <= 1'b0;
            col_q        <= '0;
            row_q        <= '0;
            ovf_q        <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            cfg_q        <= cfg_d;
            armed_q      <= armed_d;
            col_q        <= col_d;
            row_q        <= row_d;
            ovf_q        <= ovf_d;
            frame_done_q <= frame_done_d;
        end
    end

    imager_sync_fifo #(
        .WIDTH      (EW),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (~enable),
        .push    (in_win),
        .pop     (fifo_pop),
        .wr_data (fifo_wdata),
        .rd_data (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign out_valid  = ~fifo_empty;
    assign out_dat    = out_valid ? fifo_rdata[EW-1:2] : '0;
    assign out_sof    = out_valid & fifo_rdata[1];
    assign out_eol    = out_valid & fifo_rdata[0];
    assign overflow   = ovf_q;
    assign frame_done = frame_done_q;

`ifdef IMAGER_WINDOW_STATS_EN
    logic [31:0]           sum_acc_q, sum_acc_d, stats_sum_q, stats_sum_d;
    logic [DATA_WIDTH-1:0] min_acc_q, min_acc_d, stats_min_q, stats_min_d;
    logic [DATA_WIDTH-1:0] max_acc_q, max_acc_d, stats_max_q, stats_max_d;
    logic                  stats_valid_q, stats_valid_d;

    // Dropped pixels still count: accumulation follows in_win, not FIFO acceptance.
    always_comb begin
        sum_acc_d     = fv_rise ? '0 : sum_acc_q;
        min_acc_d     = fv_rise ? '1 : min_acc_q;
        max_acc_d     = fv_rise ? '0 : max_acc_q;
        stats_sum_d   = stats_sum_q;
        stats_min_d   = stats_min_q;
        stats_max_d   = stats_max_q;
        stats_valid_d = 1'b0;
        if (in_win) begin
            sum_acc_d = sum_acc_d + 32'(dat_q);
            if (dat_q < min_acc_d) min_acc_d = dat_q;
            if (dat_q > max_acc_d) max_acc_d = dat_q;
        end
        if (enable && fv_fall) begin
            stats_sum_d   = sum_acc_q;
            stats_min_d   = min_acc_q;
            stats_max_d   = max_acc_q;
            stats_valid_d = 1'b1;
        end
        if (!enable) begin
            sum_acc_d = '0;
            min_acc_d = '1;
            max_acc_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sum_acc_q     <= '0;
            min_acc_q     <= '1;
            max_acc_q     <= '0;
            stats_sum_q   <= '0;
            stats_min_q   <= '1;
            stats_max_q   <= '0;
            stats_valid_q <= 1'b0;
        end else begin
            sum_acc_q     <= sum_acc_d;
            min_acc_q     <= min_acc_d;
            max_acc_q     <= max_acc_d;
            stats_sum_q   <= stats_sum_d;
            stats_min_q   <= stats_min_d;
            stats_max_q   <= stats_max_d;
            stats_valid_q <= stats_valid_d;
        end
    end

    assign stats_sum   = stats_sum_q;
    assign stats_min   = stats_min_q;
    assign stats_max   = stats_max_q;
    assign stats_valid = stats_valid_q;
`else
    assign stats_sum   = '0;
    assign stats_min   = '0;
    assign stats_max   = '0;
    assign stats_valid = 1'b0;
`endif

endmodule

// File: tb/tb_imager_window_packer.sv
// Scoreboard bench for imager_window_packer: a frame-level crop model fills the
// expected-pixel and per-frame statistics queues; a negedge monitor drains them.
module tb_imager_window_packer;

    localparam int DW    = 10;
    localparam int RWID  = 12;
    localparam int CWID  = 12;
    localparam int DEPTH = 16;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            enable = 1'b0;
    logic [RWID-1:0] win_row_start = '0;
    logic [CWID-1:0] win_col_start = '0;
    logic [RWID-1:0] win_rows = '0;
    logic [CWID-1:0] win_cols = '0;
    logic            fv = 1'b0;
    logic            lv = 1'b0;
    logic [DW-1:0]   dat = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [DW-1:0]   out_dat;
    logic            out_sof;
    logic            out_eol;
    logic            overflow;
    logic            frame_done;
    logic [31:0]     stats_sum;
    logic [DW-1:0]   stats_min;
    logic [DW-1:0]   stats_max;
    logic            stats_valid;

    always #5 clk = ~clk;

    imager_window_packer dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .enable        (enable),
        .win_row_start (win_row_start),
        .win_col_start (win_col_start),
        .win_rows      (win_rows),
        .win_cols      (win_cols),
        .fv            (fv),
        .lv            (lv),
        .dat           (dat),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_dat       (out_dat),
        .out_sof       (out_sof),
        .out_eol       (out_eol),
        .overflow      (overflow),
        .frame_done    (frame_done),
        .stats_sum     (stats_sum),
        .stats_min     (stats_min),
        .stats_max     (stats_max),
        .stats_valid   (stats_valid)
    );

    typedef struct packed {
        logic [DW-1:0] dat;
        logic          sof;
        logic          eol;
    } pix_t;

    typedef struct {
        bit     chk;
        longint sum;
        int     mn;
        int     mx;
    } st_t;

    pix_t exp_q[$];
    st_t  st_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   fd_seen = 0;
    int   fd_exp = 0;
    int   valid_cycles = 0;
    int   pix[16][16];
    pix_t mon_e;
    st_t  mon_s;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (out_valid) valid_cycles++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_out: got dat %0d expected no output", out_dat);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("out_dat", out_dat, mon_e.dat);
                    check("out_sof", out_sof, mon_e.sof);
                    check("out_eol", out_eol, mon_e.eol);
                end
            end
            if (frame_done) begin
                fd_seen++;
`ifdef IMAGER_WINDOW_STATS_EN
                check("stats_valid_with_frame_done", stats_valid, 1);
                if (st_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL stats_queue: got frame_done expected none");
                end else begin
                    mon_s = st_q.pop_front();
                    if (mon_s.chk) begin
                        check("stats_sum", stats_sum, mon_s.sum & 64'hFFFF_FFFF);
                        check("stats_min", stats_min, mon_s.mn);
                        check("stats_max", stats_max, mon_s.mx);
                    end
                end
`else
                check("stats_valid_tied", stats_valid, 0);
                check("stats_sum_tied", stats_sum, 0);
                check("stats_min_tied", stats_min, 0);
                check("stats_max_tied", stats_max, 0);
`endif
            end else if (stats_valid) begin
                check("stats_valid_without_frame_done", stats_valid, 0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_incr(input int nrows, input int ncols);
        for (int r = 0; r < nrows; r++)
            for (int c = 0; c < ncols; c++)
                pix[r][c] = r * ncols + c;
    endtask

    task automatic set_cfg(input int rs, input int cs, input int rows, input int cols);
        win_row_start = RWID'(rs);
        win_col_start = CWID'(cs);
        win_rows      = RWID'(rows);
        win_cols      = CWID'(cols);
    endtask

    // rdy_mode: 0 ready always, 1 random while lv is high, 2 held low all frame.
    task automatic run_frame(input int nrows, input int ncols, input int rdy_mode,
                             input int chg_row, input int new_cs, input int en_row,
                             input bit expect_out);
        int   rs, cs, nr, nc, kept;
        st_t  st;
        pix_t e;
        rs = int'(win_row_start);
        cs = int'(win_col_start);
        nr = int'(win_rows);
        nc = int'(win_cols);
        kept = 0;
        st.chk = expect_out;
        st.sum = 0;
        st.mn  = (1 << DW) - 1;
        st.mx  = 0;
        for (int r = 0; r < nrows; r++) begin
            for (int c = 0; c < ncols; c++) begin
                if (r >= rs && r < rs + nr && c >= cs && c < cs + nc) begin
                    st.sum += pix[r][c];
                    if (pix[r][c] < st.mn) st.mn = pix[r][c];
                    if (pix[r][c] > st.mx) st.mx = pix[r][c];
                    if (expect_out && (rdy_mode != 2 || kept < DEPTH)) begin
                        e.dat = DW'(pix[r][c]);
                        e.sof = (r == rs && c == cs);
                        e.eol = (c == cs + nc - 1);
                        exp_q.push_back(e);
                        kept++;
                    end
                end
            end
        end
        out_ready = (rdy_mode != 2);
        fv = 1'b1;
        step();
        step();
        for (int r = 0; r < nrows; r++) begin
            if (r == chg_row) win_col_start = CWID'(new_cs);
            if (r == en_row) enable = 1'b1;
            for (int c = 0; c < ncols; c++) begin
                lv  = 1'b1;
                dat = DW'(pix[r][c]);
                if (rdy_mode == 1) out_ready = ($urandom % 4) != 0;
                step();
            end
            lv  = 1'b0;
            dat = '0;
            out_ready = (rdy_mode != 2);
            repeat (10) step();
        end
        fv = 1'b0;
        if (enable) begin
            fd_exp++;
            st_q.push_back(st);
        end
        repeat (6) step();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            step();
            n++;
        end
        check("drain_remaining", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int nrows, ncols;

        repeat (3) step();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sof", out_sof, 0);
        check("rst_out_eol", out_eol, 0);
        check("rst_out_dat", out_dat, 0);
        check("rst_overflow", overflow, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_stats_valid", stats_valid, 0);
        check("rst_stats_sum", stats_sum, 0);
        check("rst_stats_max", stats_max, 0);
`ifdef IMAGER_WINDOW_STATS_EN
        check("rst_stats_min", stats_min, (1 << DW) - 1);
`else
        check("rst_stats_min", stats_min, 0);
`endif
        reset_n = 1'b1;
        enable  = 1'b1;
        repeat (4) step();

        // Basic crop, then a mid-frame column-start change seen only next frame.
        fill_incr(4, 8);
        set_cfg(1, 2, 2, 3);
        run_frame(4, 8, 0, -1, 0, -1, 1);
        drain();
        check("basic_overflow", overflow, 0);
        run_frame(4, 8, 0, 1, 0, -1, 1);
        drain();
        run_frame(4, 8, 0, -1, 0, -1, 1);
        drain();

        // Randomised frames and windows with random backpressure during lines.
        for (int f = 0; f < 12; f++) begin
            nrows = $urandom_range(2, 6);
            ncols = $urandom_range(4, 12);
            for (int r = 0; r < nrows; r++)
                for (int c = 0; c < ncols; c++)
                    pix[r][c] = $urandom % (1 << DW);
            set_cfg($urandom_range(0, nrows), $urandom_range(0, ncols - 1),
                    $urandom_range(0, nrows), $urandom_range(0, 8));
            run_frame(nrows, ncols, 1, -1, 0, -1, 1);
        end
        drain();
        check("random_overflow", overflow, 0);

        // Zero-width window.
        fill_incr(4, 8);
        set_cfg(0, 0, 4, 0);
        valid_cycles = 0;
        run_frame(4, 8, 0, -1, 0, -1, 1);
        run_frame(4, 8, 0, -1, 0, -1, 1);
        check("zero_win_valid_cycles", valid_cycles, 0);

        // Full-frame backpressure: 32 pixels into 16 entries.
        set_cfg(0, 0, 4, 8);
        run_frame(4, 8, 2, -1, 0, -1, 1);
        repeat (3) step();
        check("bp_overflow_set", overflow, 1);
        check("bp_out_valid", out_valid, 1);
        out_ready = 1'b1;
        drain();
        set_cfg(1, 2, 2, 3);
        run_frame(4, 8, 0, -1, 0, -1, 1);
        drain();
        check("bp_overflow_sticky", overflow, 1);

        // Enable drop with 5 entries queued, then a re-enable mid-frame.
        set_cfg(0, 0, 1, 5);
        run_frame(2, 8, 2, -1, 0, -1, 1);
        repeat (3) step();
        check("en_pre_out_valid", out_valid, 1);
        check("en_pre_overflow", overflow, 1);
        enable = 1'b0;
        exp_q.delete();
        step();
        check("en_drop_out_valid", out_valid, 0);
        check("en_drop_overflow", overflow, 0);
        out_ready = 1'b1;
        repeat (3) step();
        set_cfg(0, 0, 4, 8);
        valid_cycles = 0;
        run_frame(4, 8, 0, -1, 0, 1, 0);
        check("en_partial_valid_cycles", valid_cycles, 0);
        set_cfg(1, 2, 2, 3);
        run_frame(4, 8, 0, -1, 0, -1, 1);
        drain();

        repeat (5) step();
        check("frame_done_count", fd_seen, fd_exp);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
